// File: rtl/msrv32_pkg.sv
// Shared definitions for the msrv32 fetch sequencer: FSM state codes,
// next-PC select codes and the default boot address.
package msrv32_pkg;

  localparam logic [1:0] S_BOOT = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  typedef enum logic [1:0] {
    SEL_SEQ  = 2'd0,
    SEL_BR   = 2'd1,
    SEL_TRAP = 2'd2,
    SEL_MRET = 2'd3
  } pc_sel_t;

  localparam logic [31:0] BOOT_ADDR_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/msrv32_next_pc_mux.sv
// Combinational next-PC priority select (trap > mret > branch > sequential)
// with branch-target alignment check.
module msrv32_next_pc_mux
  import msrv32_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             en,
  input  logic             advance,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] pc_plus_4,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             trap_taken,
  input  logic [WIDTH-1:0] trap_vector,
  input  logic             mret,
  input  logic [WIDTH-1:0] epc,
  output logic [WIDTH-1:0] next_pc,
  output logic             redirect,
  output logic             misaligned
);

  localparam logic [WIDTH-1:0] ALIGN_MASK = ~(WIDTH'(3));

  pc_sel_t sel;
  logic    target_aligned;

  always_comb begin
    target_aligned = (branch_target[1:0] == 2'b00);
    sel = SEL_SEQ;
    if (en) begin
      if (trap_taken)                         sel = SEL_TRAP;
      else if (mret)                          sel = SEL_MRET;
      else if (branch_taken && target_aligned) sel = SEL_BR;
    end
    misaligned = en && !trap_taken && !mret && branch_taken && !target_aligned;
    redirect   = (sel != SEL_SEQ);
    // A misaligned branch freezes the PC so the trap logic sees the faulting fetch.
    unique case (sel)
      SEL_TRAP: next_pc = trap_vector & ALIGN_MASK;
      SEL_MRET: next_pc = epc & ALIGN_MASK;
      SEL_BR:   next_pc = branch_target;
      default:  next_pc = (advance && !misaligned) ? pc_plus_4 : pc;
    endcase
  end

endmodule

// File: rtl/msrv32_fetch_sequencer.sv
// Program-counter owner for the msrv32 fetch stage: boot/run/wait FSM,
// PC register, imem request handshake and registered flush/misalign pulses.
module msrv32_fetch_sequencer
  import msrv32_pkg::*;
#(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] BOOT_ADDR = WIDTH'(BOOT_ADDR_DEFAULT)
) (
  input  logic             msrv32_mp_clk_in,
  input  logic             msrv32_mp_rst_in,
  input  logic             branch_taken_in,
  input  logic [WIDTH-1:0] branch_target_in,
  input  logic             trap_taken_in,
  input  logic [WIDTH-1:0] trap_vector_in,
  input  logic             mret_in,
  input  logic [WIDTH-1:0] epc_in,
  input  logic             stall_in,
  input  logic             imem_ready_in,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] pc_plus_4_out,
  output logic             imem_req_out,
  output logic [WIDTH-1:0] imem_addr_out,
  output logic             flush_out,
  output logic             misaligned_instr_out
);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_nxt;
  logic             redirect;
  logic             misaligned;
  logic             advance;

  assign pc_out        = pc;
  assign pc_plus_4_out = pc + WIDTH'(4);
  assign imem_addr_out = pc;
  assign imem_req_out  = (state != S_BOOT);
  assign advance       = imem_req_out && imem_ready_in && !stall_in;

  msrv32_next_pc_mux #(
    .WIDTH(WIDTH)
  ) u_next_pc_mux (
    .en            (imem_req_out),
    .advance       (advance),
    .pc            (pc),
    .pc_plus_4     (pc_plus_4_out),
    .branch_taken  (branch_taken_in),
    .branch_target (branch_target_in),
    .trap_taken    (trap_taken_in),
    .trap_vector   (trap_vector_in),
    .mret          (mret_in),
    .epc           (epc_in),
    .next_pc       (pc_nxt),
    .redirect      (redirect),
    .misaligned    (misaligned)
  );

  // A redirect abandons any outstanding request and restarts fetch in S_RUN.
  always_comb begin
    state_nxt = state;
    if (redirect) begin
      state_nxt = S_RUN;
    end else begin
      unique case (state)
        S_BOOT:  state_nxt = S_RUN;
        S_RUN:   state_nxt = imem_ready_in ? S_RUN : S_WAIT;
        S_WAIT:  state_nxt = imem_ready_in ? S_RUN : S_WAIT;
        default: state_nxt = S_BOOT;
      endcase
    end
  end

  always_ff @(posedge msrv32_mp_clk_in) begin
    if (msrv32_mp_rst_in) begin
      state                <= S_BOOT;
      pc                   <= BOOT_ADDR;
      flush_out            <= 1'b0;
      misaligned_instr_out <= 1'b0;
    end else begin
      state                <= state_nxt;
      pc                   <= pc_nxt;
      flush_out            <= redirect;
      misaligned_instr_out <= misaligned;
    end
  end

endmodule

// File: tb/tb_msrv32_fetch_sequencer.sv
// Self-checking bench for msrv32_fetch_sequencer: directed scenarios followed
// by randomized traffic, all checked against a behavioural PC model.
module tb_msrv32_fetch_sequencer;

  localparam logic [31:0] BOOT = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, br, trap, mret, stall, ready;
  logic [31:0] tgt, vec, epc;
  logic [31:0] pc_out, pc_plus_4_out, imem_addr_out;
  logic        imem_req_out, flush_out, misaligned_instr_out;

  int unsigned checks = 0;
  int unsigned failures = 0;

  // Model: only "has left boot" is externally visible; run vs wait behave identically.
  logic [31:0] m_pc;
  logic        m_booted, m_flush, m_mis;

  always #5 clk = ~clk;

  msrv32_fetch_sequencer #(
    .WIDTH     (32),
    .BOOT_ADDR (BOOT)
  ) dut (
    .msrv32_mp_clk_in     (clk),
    .msrv32_mp_rst_in     (rst),
    .branch_taken_in      (br),
    .branch_target_in     (tgt),
    .trap_taken_in        (trap),
    .trap_vector_in       (vec),
    .mret_in              (mret),
    .epc_in               (epc),
    .stall_in             (stall),
    .imem_ready_in        (ready),
    .pc_out               (pc_out),
    .pc_plus_4_out        (pc_plus_4_out),
    .imem_req_out         (imem_req_out),
    .imem_addr_out        (imem_addr_out),
    .flush_out            (flush_out),
    .misaligned_instr_out (misaligned_instr_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic b, input logic [31:0] t,
                       input logic tr, input logic [31:0] v, input logic m,
                       input logic [31:0] e, input logic s, input logic rd);
    rst = r; br = b; tgt = t; trap = tr; vec = v; mret = m; epc = e; stall = s; ready = rd;
  endtask

  task automatic model_edge();
    if (rst) begin
      m_pc = BOOT; m_booted = 1'b0; m_flush = 1'b0; m_mis = 1'b0;
    end else if (!m_booted) begin
      m_booted = 1'b1; m_flush = 1'b0; m_mis = 1'b0;
    end else begin
      m_flush = 1'b0; m_mis = 1'b0;
      if (trap) begin
        m_pc = vec - (vec % 4); m_flush = 1'b1;
      end else if (mret) begin
        m_pc = epc - (epc % 4); m_flush = 1'b1;
      end else if (br) begin
        if (tgt % 4 == 0) begin
          m_pc = tgt; m_flush = 1'b1;
        end else begin
          m_mis = 1'b1;
        end
      end else if (ready && !stall) begin
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check({tag, ".pc"},    pc_out,                        m_pc);
    check({tag, ".pc4"},   pc_plus_4_out,                 m_pc + 32'd4);
    check({tag, ".addr"},  imem_addr_out,                 m_pc);
    check({tag, ".req"},   {31'd0, imem_req_out},         {31'd0, m_booted});
    check({tag, ".flush"}, {31'd0, flush_out},            {31'd0, m_flush});
    check({tag, ".mis"},   {31'd0, misaligned_instr_out}, {31'd0, m_mis});
  endtask

  initial begin
    m_pc = BOOT; m_booted = 1'b0; m_flush = 1'b0; m_mis = 1'b0;

    // Reset for two edges, then one boot cycle without a request.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
    tick("rst0");
    tick("rst1");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick("boot");

    // Sequential fetch 0 -> 0x10, then imem wait holds the PC.
    for (int i = 0; i < 4; i++) tick("seq");
    check("seq.end", pc_out, 32'h10);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick("wait");
    check("wait.hold", pc_out, 32'h10);

    // Advance to 0x20, then simultaneous branch and trap: trap wins, vector aligned.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) tick("seq2");
    check("seq2.end", pc_out, 32'h20);
    drive(0, 1, 32'h100, 1, 32'h203, 0, 0, 0, 1);
    tick("trap");
    check("trap.pc", pc_out, 32'h200);
    check("trap.flush", {31'd0, flush_out}, 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick("trap.after");
    check("trap.flush1cyc", {31'd0, flush_out}, 32'd0);

    // Misaligned branch: PC holds, misalign pulse, no flush.
    drive(0, 1, 32'h102, 0, 0, 0, 0, 0, 1);
    tick("misal");
    check("misal.pc", pc_out, 32'h200);
    check("misal.flag", {31'd0, misaligned_instr_out}, 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick("misal.after");

    // mret under stall still redirects; then stall holds the PC.
    drive(0, 0, 0, 0, 0, 1, 32'h8000_0040, 1, 1);
    tick("mret");
    check("mret.pc", pc_out, 32'h8000_0040);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
    tick("stall");
    tick("stall");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick("unstall");
    check("unstall.pc", pc_out, 32'h8000_0044);

    // Wrap from 0xFFFF_FFFC to 0, then reset while waiting.
    drive(0, 0, 0, 1, 32'hFFFF_FFFE, 0, 0, 0, 0);
    tick("top");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick("wrap");
    check("wrap.pc", pc_out, 32'h0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick("towait");
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick("rstwait");
    check("rstwait.req", {31'd0, imem_req_out}, 32'd0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick("reboot");

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] t;
      t = $urandom;
      if ($urandom_range(0, 1) == 0) t[1:0] = 2'b00;
      drive($urandom_range(0, 31) == 0, $urandom_range(0, 4) == 0, t,
            $urandom_range(0, 9) == 0, $urandom, $urandom_range(0, 9) == 0, $urandom,
            $urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0);
      tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
